store_buffer: RTL and testbench

- Write-side counterpart to the register-writeback path: queues store requests (address, data) from the datapath and drains them into the single-port data RAM.
- Memory reads always have priority on the RAM port. Stores drain only in cycles without a load.
- Detects loads that hit a pending store. Optionally forwards the youngest matching store data to the load path.
- Sits between the execute stage and the data RAM. Its load-side outputs feed the writeback value mux.

---
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer.sv | 74 +++++++
 tb/tb_store_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: store request, load probe and RAM drain signals of the store buffer
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW = 8,
    parameter int DW = 8
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic st_ready;
    logic ld_active;
    logic [AW-1:0] ld_addr;
    logic ld_hit;
    logic [DW-1:0] ld_fwd_data;
    logic ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [CW-1:0] count;
    logic empty;
    logic full;
    modport master (
        output st_valid, st_addr, st_data, ld_active, ld_addr,
        input st_ready, ld_hit, ld_fwd_data, ram_we, ram_addr, ram_wdata, count, empty, full
    );
    modport slave (
        input st_valid, st_addr, st_data, ld_active, ld_addr,
        output st_ready, ld_hit, ld_fwd_data, ram_we, ram_addr, ram_wdata, count, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue draining into the data RAM when no load uses the port; STORE_BUFFER_FWD_EN enables youngest-match load forwarding
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW = 8,
    parameter int DW = 8
) (
    input logic clk,
    input logic rst,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] match;
    logic [PW-1:0] head, tail;
    logic [PW:0] cnt;
    logic push, pop;
    assign bus.full = cnt == (PW+1)'(DEPTH);
    assign bus.empty = cnt == '0;
    assign bus.count = cnt;
    assign bus.st_ready = !bus.full;
    assign push = bus.st_valid && bus.st_ready;
    assign pop = bus.ram_we;
    assign bus.ram_we = !bus.empty && !bus.ld_active;
    assign bus.ram_addr = addr_q[head];
    assign bus.ram_wdata = data_q[head];
    assign bus.ld_hit = bus.ld_active && |match;
    // entry payload needs no reset; only valid bits gate its use
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
        end
    end
    // pointers, occupancy and valid bits; reset drops every pending store
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[tail] <= 1'b1;
                tail <= tail + 1'b1;
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head <= head + 1'b1;
            end
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    // per-entry address compare against the load; same-cycle push is not yet valid
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = valid_q[i] && addr_q[i] == bus.ld_addr;
    end
`ifdef STORE_BUFFER_FWD_EN
    logic [DW-1:0] fwd;
    assign bus.ld_fwd_data = fwd;
    // walk oldest to youngest so the last match seen is the youngest store
    always_comb begin
        fwd = '0;
        for (int j = 0; j < DEPTH; j++)
            if (bus.ld_active && match[head + PW'(j)])
                fwd = data_q[head + PW'(j)];
    end
`else
    assign bus.ld_fwd_data = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table plus reset and RAM-content sequences for store_buffer
module tb_store_buffer;
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct {
        logic sv;
        logic [7:0] sa, sd;
        logic la;
        logic [7:0] lad;
        logic rdy, hit;
        logic [7:0] fwd;
        logic we;
        logic [7:0] ra, rd;
        int cnt;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] ram [256];
    logic written [256];
    int nvec = 0;
    int nerr = 0;
    vec_t v [$];
    store_buffer_if #(.DEPTH(4), .AW(8), .DW(8)) bus ();
    store_buffer #(.DEPTH(4), .AW(8), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
            written[bus.ram_addr] <= 1'b1;
        end
    end
    function automatic logic [7:0] fx(logic [7:0] x);
        return FWD ? x : 8'h00;
    endfunction
    function automatic vec_t mk(logic sv, logic [7:0] sa, logic [7:0] sd, logic la, logic [7:0] lad,
                                logic rdy, logic hit, logic [7:0] fwd, logic we,
                                logic [7:0] ra, logic [7:0] rd, int cnt);
        vec_t r;
        r.sv = sv; r.sa = sa; r.sd = sd; r.la = la; r.lad = lad;
        r.rdy = rdy; r.hit = hit; r.fwd = fwd; r.we = we; r.ra = ra; r.rd = rd; r.cnt = cnt;
        return r;
    endfunction
    task automatic chk(string n, int idx, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (step %0d): got %0h want %0h", n, idx, act, exp);
        end
    endtask
    task automatic drive(logic sv, logic [7:0] sa, logic [7:0] sd, logic la, logic [7:0] lad);
        @(negedge clk);
        bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd;
        bus.ld_active = la; bus.ld_addr = lad;
        #2;
    endtask
    initial begin
        for (int i = 0; i < 256; i++) begin
            written[i] = 1'b0;
            ram[i] = 8'h00;
        end
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
        bus.ld_active = 1'b1; bus.ld_addr = '0;
        // reset state, then reset while two stores are pending
        drive(0, 8'h00, 8'h00, 1, 8'h10);
        drive(0, 8'h00, 8'h00, 1, 8'h10);
        rst = 1'b0;
        #1;
        chk("rst_ready", -1, bus.st_ready, 1);
        chk("rst_empty", -1, bus.empty, 1);
        chk("rst_full", -1, bus.full, 0);
        chk("rst_we", -1, bus.ram_we, 0);
        chk("rst_hit", -1, bus.ld_hit, 0);
        chk("rst_fwd", -1, bus.ld_fwd_data, 0);
        chk("rst_count", -1, bus.count, 0);
        drive(1, 8'h10, 8'h11, 1, 8'h10);
        drive(1, 8'h11, 8'h22, 1, 8'h10);
        drive(0, 8'h00, 8'h00, 1, 8'h10);
        chk("pre_rst_count", -2, bus.count, 2);
        chk("pre_rst_hit", -2, bus.ld_hit, 1);
        rst = 1'b1;
        drive(0, 8'h00, 8'h00, 0, 8'h10);
        rst = 1'b0;
        #1;
        chk("midrst_count", -3, bus.count, 0);
        chk("midrst_empty", -3, bus.empty, 1);
        chk("midrst_we", -3, bus.ram_we, 0);
        chk("midrst_hit", -3, bus.ld_hit, 0);
        // single store
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        v.push_back(mk(1, 8'h20, 8'hAB, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 8'h20, 8'hAB, 1));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        // fill under a held load, refused fifth store, then in-order drain
        v.push_back(mk(1, 8'h50, 8'h01, 1, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        v.push_back(mk(1, 8'h51, 8'h02, 1, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1));
        v.push_back(mk(1, 8'h52, 8'h03, 1, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 2));
        v.push_back(mk(1, 8'h53, 8'h04, 1, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 3));
        v.push_back(mk(1, 8'h54, 8'h05, 1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4));
        v.push_back(mk(1, 8'h54, 8'h05, 1, 8'h52, 0, 1, fx(8'h03), 0, 8'h00, 8'h00, 4));
        v.push_back(mk(1, 8'h54, 8'h05, 0, 8'h52, 0, 0, 8'h00, 1, 8'h50, 8'h01, 4));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 8'h51, 8'h02, 3));
        v.push_back(mk(1, 8'h60, 8'h0A, 0, 8'h00, 1, 0, 8'h00, 1, 8'h52, 8'h03, 2));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 8'h53, 8'h04, 2));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 8'h60, 8'h0A, 1));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        // six stores streaming through across the pointer wrap
        v.push_back(mk(1, 8'h70, 8'hA0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        v.push_back(mk(1, 8'h71, 8'hA1, 0, 8'h00, 1, 0, 8'h00, 1, 8'h70, 8'hA0, 1));
        v.push_back(mk(1, 8'h72, 8'hA2, 0, 8'h00, 1, 0, 8'h00, 1, 8'h71, 8'hA1, 1));
        v.push_back(mk(1, 8'h73, 8'hA3, 0, 8'h00, 1, 0, 8'h00, 1, 8'h72, 8'hA2, 1));
        v.push_back(mk(1, 8'h74, 8'hA4, 0, 8'h00, 1, 0, 8'h00, 1, 8'h73, 8'hA3, 1));
        v.push_back(mk(1, 8'h75, 8'hA5, 0, 8'h00, 1, 0, 8'h00, 1, 8'h74, 8'hA4, 1));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 8'h75, 8'hA5, 1));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        v.push_back(mk(1, 8'h99, 8'h77, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 8'h99, 8'h77, 1));
        // load hits, same-cycle push excluded, youngest match forwarded across wrap
        v.push_back(mk(1, 8'h30, 8'h55, 0, 8'h30, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        v.push_back(mk(0, 8'h00, 8'h00, 1, 8'h30, 1, 1, fx(8'h55), 0, 8'h00, 8'h00, 1));
        v.push_back(mk(0, 8'h00, 8'h00, 1, 8'h31, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1));
        v.push_back(mk(1, 8'h30, 8'h66, 1, 8'h30, 1, 1, fx(8'h55), 0, 8'h00, 8'h00, 1));
        v.push_back(mk(0, 8'h00, 8'h00, 1, 8'h30, 1, 1, fx(8'h66), 0, 8'h00, 8'h00, 2));
        v.push_back(mk(1, 8'h40, 8'h01, 1, 8'h30, 1, 1, fx(8'h66), 0, 8'h00, 8'h00, 2));
        v.push_back(mk(1, 8'h40, 8'h02, 1, 8'h40, 1, 1, fx(8'h01), 0, 8'h00, 8'h00, 3));
        v.push_back(mk(0, 8'h00, 8'h00, 1, 8'h40, 0, 1, fx(8'h02), 0, 8'h00, 8'h00, 4));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h40, 0, 0, 8'h00, 1, 8'h30, 8'h55, 4));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h40, 1, 0, 8'h00, 1, 8'h30, 8'h66, 3));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h40, 1, 0, 8'h00, 1, 8'h40, 8'h01, 2));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h40, 1, 0, 8'h00, 1, 8'h40, 8'h02, 1));
        v.push_back(mk(0, 8'h00, 8'h00, 0, 8'h40, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0));
        foreach (v[k]) begin
            drive(v[k].sv, v[k].sa, v[k].sd, v[k].la, v[k].lad);
            chk("st_ready", k, bus.st_ready, v[k].rdy);
            chk("ld_hit", k, bus.ld_hit, v[k].hit);
            chk("ld_fwd_data", k, bus.ld_fwd_data, v[k].fwd);
            chk("ram_we", k, bus.ram_we, v[k].we);
            chk("count", k, bus.count, v[k].cnt);
            chk("empty", k, bus.empty, v[k].cnt == 0);
            chk("full", k, bus.full, v[k].cnt == 4);
            if (v[k].we) begin
                chk("ram_addr", k, bus.ram_addr, v[k].ra);
                chk("ram_wdata", k, bus.ram_wdata, v[k].rd);
            end
        end
        drive(0, 8'h00, 8'h00, 0, 8'h00);
        chk("discard_0x10", -4, written[8'h10], 0);
        chk("discard_0x11", -4, written[8'h11], 0);
        chk("ram_0x20", -4, ram[8'h20], 8'hAB);
        chk("ram_0x30_last", -4, ram[8'h30], 8'h66);
        chk("ram_0x40_last", -4, ram[8'h40], 8'h02);
        chk("ram_0x75", -4, ram[8'h75], 8'hA5);
        chk("refused_0x54", -4, written[8'h54], 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
